i2c_mem_bridge: RTL and testbench

I2C_MEM_BRIDGE -- requirements
Module: i2c_mem_bridge

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_sp_ram.sv | 30 +++
 rtl/i2c_mem_bridge.sv | 174 +++++++++++++++++
 tb/tb_i2c_mem_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-memory bridge.
//   bridge_state_t : bridge FSM encoding
//   ACK / NACK     : ack_nack encodings
//   TX_IDLE_BYTE   : byte returned for reads when no memory data applies
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_READ,
    ST_ERR
  } bridge_state_t;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_sp_ram.sv
// Single-port RAM backing the bridge register file.
//   clk     : clock
//   i_en    : port enable (read or write)
//   i_we    : write enable (write wins the port when set)
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : registered read data, valid the cycle after an enabled read
// Contents are not reset.
module i2c_sp_ram #(
  parameter int DEPTH = 128,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      o_rdata       <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/i2c_mem_bridge.sv
// Bridges an I2C target byte engine onto an 8-bit register memory with an
// auto-incrementing pointer (EEPROM-style register access).
//   clk, rst_n             : clock, async active-low reset
//   xfer_start / xfer_rw   : device address matched, R/W bit
//   xfer_stop              : STOP or repeated START
//   rx_valid / rx_data     : received byte; answered by ack_valid/ack_nack
//   tx_req                 : engine wants next read byte; answered by
//                            tx_valid/tx_data two cycles later
//   master_nack            : master NACKed the last read byte
//   ptr                    : current memory pointer
module i2c_mem_bridge
  import i2c_pkg::*;
#(
  parameter int ADDR_BYTES = 1,
  parameter int DEPTH      = 128,
  parameter int WRAP       = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     xfer_start,
  input  logic                     xfer_rw,
  input  logic                     xfer_stop,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     ack_valid,
  output logic                     ack_nack,
  input  logic                     tx_req,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     master_nack,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW        = $clog2(DEPTH);
  localparam int SW        = 8 * ADDR_BYTES;
  localparam int RD_STAGES = 2;

  bridge_state_t    r_state, w_nstate;
  logic [PW-1:0]    r_ptr, w_ptr_nxt, w_adv_ptr;
  logic [SW-1:0]    r_shadow, w_shadow_nxt, w_addr_val;
  logic             r_acnt, w_acnt_nxt;
  logic             r_sat, w_sat_nxt, w_adv_sat, w_at_end;
  logic             r_mnack, w_mnack_nxt;
  logic             w_ack_go, w_ack_n, w_we, w_rd_go;
  logic             r_ack_valid, r_ack_nack;
  logic [RD_STAGES:1] r_vld_pipe;
  logic             r_ff_pipe;
  logic [7:0]       r_tx_data, w_rdata;

  // Pointer byte assembly, MSB first. In 1-byte mode the shift clears the
  // shadow contribution entirely.
  assign w_addr_val = (r_shadow << 8) | SW'(rx_data);

  // End-of-memory rule shared by writes and reads. r_sat marks that the
  // last location has been consumed with WRAP=0.
  assign w_at_end  = (r_ptr == PW'(DEPTH - 1));
  assign w_adv_ptr = w_at_end ? ((WRAP != 0) ? '0 : r_ptr) : r_ptr + 1'b1;
  assign w_adv_sat = w_at_end && (WRAP == 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate     = r_state;
    w_ptr_nxt    = r_ptr;
    w_shadow_nxt = r_shadow;
    w_acnt_nxt   = r_acnt;
    w_sat_nxt    = r_sat;
    w_mnack_nxt  = r_mnack;
    w_ack_go     = 1'b0;
    w_ack_n      = ACK;
    w_we         = 1'b0;
    w_rd_go      = 1'b0;
    // A start outside IDLE behaves as stop+start; either one drops any byte
    // arriving in the same cycle and any partial pointer.
    if (xfer_stop || xfer_start) begin
      w_nstate    = ST_IDLE;
      w_acnt_nxt  = 1'b0;
      w_sat_nxt   = 1'b0;
      w_mnack_nxt = 1'b0;
      if (xfer_start) w_nstate = xfer_rw ? ST_READ : ST_ADDR;
    end else begin
      unique case (r_state)
        ST_ADDR: if (rx_valid) begin
          w_ack_go     = 1'b1;
          w_shadow_nxt = w_addr_val;
          if (r_acnt == 1'(ADDR_BYTES - 1)) begin
            w_acnt_nxt = 1'b0;
            if (32'(w_addr_val) < DEPTH) begin
              w_ptr_nxt = w_addr_val[PW-1:0];
              w_nstate  = ST_WRITE;
            end else begin
              w_ack_n  = NACK;
              w_nstate = ST_ERR;
            end
          end else begin
            w_acnt_nxt = r_acnt + 1'b1;
          end
        end
        ST_WRITE: if (rx_valid) begin
          w_ack_go = 1'b1;
          if (r_sat) begin
            w_ack_n = NACK;
          end else begin
            w_we      = 1'b1;
            w_ptr_nxt = w_adv_ptr;
            w_sat_nxt = w_adv_sat;
          end
        end
        ST_READ: begin
          if (master_nack) w_mnack_nxt = 1'b1;
          if (tx_req) begin
            w_rd_go = 1'b1;
            if (!r_mnack && !master_nack && !r_sat) begin
              w_ptr_nxt = w_adv_ptr;
              w_sat_nxt = w_adv_sat;
            end
          end
        end
        ST_ERR: if (rx_valid) begin
          w_ack_go = 1'b1;
          w_ack_n  = NACK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_shadow    <= '0;
      r_acnt      <= 1'b0;
      r_sat       <= 1'b0;
      r_mnack     <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack_nack  <= ACK;
      r_vld_pipe  <= '0;
      r_ff_pipe   <= 1'b0;
      r_tx_data   <= TX_IDLE_BYTE;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_shadow    <= w_shadow_nxt;
      r_acnt      <= w_acnt_nxt;
      r_sat       <= w_sat_nxt;
      r_mnack     <= w_mnack_nxt;
      r_ack_valid <= w_ack_go;
      if (w_ack_go) r_ack_nack <= w_ack_n;
      // Read pipe: stage 1 = RAM data out, stage 2 = tx_data registered.
      r_vld_pipe  <= {r_vld_pipe[RD_STAGES-1:1], w_rd_go};
      if (w_rd_go) r_ff_pipe <= r_sat;
      if (r_vld_pipe[1]) r_tx_data <= r_ff_pipe ? TX_IDLE_BYTE : w_rdata;
    end
  end

  // Write and read both address the RAM at r_ptr; states never overlap.
  i2c_sp_ram #(.DEPTH(DEPTH), .W(8)) u_ram (
    .clk     (clk),
    .i_en    (w_we | w_rd_go),
    .i_we    (w_we),
    .i_addr  (r_ptr),
    .i_wdata (rx_data),
    .o_rdata (w_rdata)
  );

  assign ack_valid = r_ack_valid;
  assign ack_nack  = r_ack_nack;
  assign tx_valid  = r_vld_pipe[RD_STAGES];
  assign tx_data   = r_tx_data;
  assign ptr       = r_ptr;

endmodule

// File: tb/tb_i2c_mem_bridge.sv
// Directed bench for i2c_mem_bridge. Three instances:
//   0: ADDR_BYTES=1 DEPTH=128 WRAP=1
//   1: ADDR_BYTES=1 DEPTH=128 WRAP=0
//   2: ADDR_BYTES=2 DEPTH=128 WRAP=1
module tb_i2c_mem_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       xs [3], xrw [3], xstp [3], rxv [3], txr [3], mn [3];
  logic [7:0] rxd [3];
  logic       av [3], an [3], tv [3];
  logic [7:0] td [3];
  logic [6:0] pt [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2c_mem_bridge #(.ADDR_BYTES(1), .DEPTH(128), .WRAP(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .xfer_start(xs[0]), .xfer_rw(xrw[0]),
    .xfer_stop(xstp[0]), .rx_valid(rxv[0]), .rx_data(rxd[0]),
    .ack_valid(av[0]), .ack_nack(an[0]), .tx_req(txr[0]), .tx_valid(tv[0]),
    .tx_data(td[0]), .master_nack(mn[0]), .ptr(pt[0]));

  i2c_mem_bridge #(.ADDR_BYTES(1), .DEPTH(128), .WRAP(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .xfer_start(xs[1]), .xfer_rw(xrw[1]),
    .xfer_stop(xstp[1]), .rx_valid(rxv[1]), .rx_data(rxd[1]),
    .ack_valid(av[1]), .ack_nack(an[1]), .tx_req(txr[1]), .tx_valid(tv[1]),
    .tx_data(td[1]), .master_nack(mn[1]), .ptr(pt[1]));

  i2c_mem_bridge #(.ADDR_BYTES(2), .DEPTH(128), .WRAP(1)) u_a2 (
    .clk(clk), .rst_n(rst_n), .xfer_start(xs[2]), .xfer_rw(xrw[2]),
    .xfer_stop(xstp[2]), .rx_valid(rxv[2]), .rx_data(rxd[2]),
    .ack_valid(av[2]), .ack_nack(an[2]), .tx_req(txr[2]), .tx_valid(tv[2]),
    .tx_data(td[2]), .master_nack(mn[2]), .ptr(pt[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start(input int i, input logic rw);
    @(negedge clk); xs[i] = 1'b1; xrw[i] = rw;
    @(posedge clk); #1 xs[i] = 1'b0; xrw[i] = 1'b0;
  endtask

  task automatic stop(input int i);
    @(negedge clk); xstp[i] = 1'b1;
    @(posedge clk); #1 xstp[i] = 1'b0;
  endtask

  task automatic wr(input int i, input logic [7:0] d, input logic exp_n, input string tag);
    @(negedge clk); rxv[i] = 1'b1; rxd[i] = d;
    @(posedge clk); #1 rxv[i] = 1'b0;
    chk({tag, ".av"}, 32'(av[i]), 32'd1);
    chk({tag, ".an"}, 32'(an[i]), 32'(exp_n));
  endtask

  task automatic rd(input int i, input logic [7:0] exp, input string tag);
    @(negedge clk); txr[i] = 1'b1;
    @(posedge clk); #1 txr[i] = 1'b0;
    chk({tag, ".tv1"}, 32'(tv[i]), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".tv2"}, 32'(tv[i]), 32'd1);
    chk({tag, ".td"},  32'(td[i]), 32'(exp));
  endtask

  // A byte that must draw no ack (ignored state or killed by a stop).
  task automatic rx_noack(input int i, input logic [7:0] d, input logic with_stop, input string tag);
    @(negedge clk); rxv[i] = 1'b1; rxd[i] = d; xstp[i] = with_stop;
    @(posedge clk); #1 rxv[i] = 1'b0; xstp[i] = 1'b0;
    chk({tag, ".av"}, 32'(av[i]), 32'd0);
  endtask

  task automatic txreq_ignored(input int i, input string tag);
    @(negedge clk); txr[i] = 1'b1;
    @(posedge clk); #1 txr[i] = 1'b0;
    chk({tag, ".tv1"}, 32'(tv[i]), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".tv2"}, 32'(tv[i]), 32'd0);
  endtask

  task automatic mnack(input int i);
    @(negedge clk); mn[i] = 1'b1;
    @(posedge clk); #1 mn[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xs[i] = 0; xrw[i] = 0; xstp[i] = 0; rxv[i] = 0; txr[i] = 0; mn[i] = 0; rxd[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.ptr", i), 32'(pt[i]), 32'h0);
      chk($sformatf("rst%0d.av", i),  32'(av[i]), 32'h0);
      chk($sformatf("rst%0d.an", i),  32'(an[i]), 32'h0);
      chk($sformatf("rst%0d.tv", i),  32'(tv[i]), 32'h0);
      chk($sformatf("rst%0d.td", i),  32'(td[i]), 32'hFF);
    end
    @(negedge clk); rst_n = 1'b1;

    // ---- instance 0: WRAP=1 ----
    start(0, 0);
    wr(0, 8'h10, 1'b0, "w40.a");
    wr(0, 8'hA5, 1'b0, "w40.d0");
    wr(0, 8'h5A, 1'b0, "w40.d1");
    stop(0);
    chk("w40.ptr", 32'(pt[0]), 32'h12);

    start(0, 0); wr(0, 8'h10, 1'b0, "r41.a"); stop(0);
    start(0, 1);
    rd(0, 8'hA5, "r41.b0");
    rd(0, 8'h5A, "r41.b1");
    rx_noack(0, 8'h33, 1'b0, "rxinread");
    chk("r41.ptr", 32'(pt[0]), 32'h12);
    stop(0);

    // master NACK freezes the pointer for the rest of the read
    start(0, 0); wr(0, 8'h10, 1'b0, "mn.a"); stop(0);
    start(0, 1);
    rd(0, 8'hA5, "mn.b0");
    mnack(0);
    rd(0, 8'h5A, "mn.b1");
    rd(0, 8'h5A, "mn.b2");
    chk("mn.ptr", 32'(pt[0]), 32'h11);
    stop(0);

    // out-of-range pointer -> ERR, data NACKed, nothing stored
    start(0, 0);
    wr(0, 8'h90, 1'b1, "e42.a");
    wr(0, 8'h33, 1'b1, "e42.d");
    stop(0);
    chk("e42.ptr", 32'(pt[0]), 32'h11);
    start(0, 0); wr(0, 8'h11, 1'b0, "e42.ra");
    start(0, 1);                      // repeated START without stop
    rd(0, 8'h5A, "e42.rd");
    chk("e42.ptr2", 32'(pt[0]), 32'h12);
    stop(0);

    // wrap at end of memory
    start(0, 0);
    wr(0, 8'h7F, 1'b0, "w43.a");
    wr(0, 8'h11, 1'b0, "w43.d0");
    wr(0, 8'h22, 1'b0, "w43.d1");
    chk("w43.ptr", 32'(pt[0]), 32'h01);
    stop(0);
    start(0, 0); wr(0, 8'h7F, 1'b0, "w43.ra"); stop(0);
    start(0, 1);
    rd(0, 8'h11, "w43.r0");
    rd(0, 8'h22, "w43.r1");
    chk("w43.ptr2", 32'(pt[0]), 32'h01);
    stop(0);

    // stop colliding with a data byte
    start(0, 0);
    wr(0, 8'h20, 1'b0, "s45.a");
    wr(0, 8'h44, 1'b0, "s45.d0");
    wr(0, 8'h99, 1'b0, "s45.d1");
    stop(0);
    start(0, 0); wr(0, 8'h21, 1'b0, "s45.a2");
    rx_noack(0, 8'h77, 1'b1, "s45.stp");
    chk("s45.ptr", 32'(pt[0]), 32'h21);
    rx_noack(0, 8'h55, 1'b0, "s45.idle");
    txreq_ignored(0, "txidle");
    start(0, 1);
    rd(0, 8'h99, "s45.rd");
    stop(0);

    // ---- instance 1: WRAP=0 saturation ----
    start(1, 0);
    wr(1, 8'h7F, 1'b0, "w43s.a");
    wr(1, 8'h11, 1'b0, "w43s.d0");
    wr(1, 8'h22, 1'b1, "w43s.d1");
    chk("w43s.ptr", 32'(pt[1]), 32'h7F);
    stop(1);
    start(1, 1);
    rd(1, 8'h11, "w43s.r0");
    rd(1, 8'hFF, "w43s.r1");
    chk("w43s.ptr2", 32'(pt[1]), 32'h7F);
    stop(1);

    // ---- instance 2: two pointer bytes ----
    start(2, 0);
    wr(2, 8'h00, 1'b0, "a2.a0");
    wr(2, 8'h05, 1'b0, "a2.a1");
    wr(2, 8'hC3, 1'b0, "a2.d0");
    wr(2, 8'hD4, 1'b0, "a2.d1");
    chk("a2.ptr", 32'(pt[2]), 32'h07);
    stop(2);
    start(2, 0); wr(2, 8'h00, 1'b0, "a2.b0"); wr(2, 8'h05, 1'b0, "a2.b1"); stop(2);
    chk("a2.ptr5", 32'(pt[2]), 32'h05);
    start(2, 0); wr(2, 8'h00, 1'b0, "a44.p"); stop(2);
    chk("a44.ptr", 32'(pt[2]), 32'h05);
    start(2, 1);
    rd(2, 8'hC3, "a44.rd");
    stop(2);
    chk("a44.ptr2", 32'(pt[2]), 32'h06);
    start(2, 0);
    wr(2, 8'h01, 1'b0, "a2.big0");
    wr(2, 8'h00, 1'b1, "a2.big1");
    stop(2);
    chk("a2.bigptr", 32'(pt[2]), 32'h06);

    // ---- reset mid-transaction; memory survives ----
    start(0, 0);
    wr(0, 8'h30, 1'b0, "r37.a");
    @(negedge clk); rxv[0] = 1'b1; rxd[0] = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    chk("r37.ptr", 32'(pt[0]), 32'h0);
    chk("r37.av",  32'(av[0]), 32'h0);
    @(posedge clk); #1 rxv[0] = 1'b0;
    chk("r37.av2", 32'(av[0]), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    start(0, 1);
    rd(0, 8'h22, "r37.mem0");
    stop(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
